cursor_paint_ctrl: RTL and testbench
====================================

CURSOR_PAINT_CTRL -- requirements
Module: cursor_paint_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 64, screen width in pixels.
REQ-002 SHALL have parameter V_RES, default 64, screen height in pixels.
REQ-003 SHALL have parameter COLOR_BITS, default 24, pixel colour width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pkt_valid  input  1  one-cycle strobe: new mouse packet.
REQ-007 SHALL have ports btn_left, btn_right, btn_middle  input  1 each  button states, qualified by pkt_valid.
REQ-008 SHALL have ports delta_x, delta_y  input  8 each  two's-complement movement, qualified by pkt_valid.
REQ-009 SHALL have ports cursor_x  output  clog2(H_RES) and cursor_y  output  clog2(V_RES)  current cursor position.
REQ-010 SHALL have port wr_req  output  1  framebuffer write request.
REQ-011 SHALL have port wr_addr  output  clog2(H_RES*V_RES)  pixel address, y*H_RES+x.
REQ-012 SHALL have port wr_data  output  COLOR_BITS  pixel colour.
REQ-013 SHALL have port wr_ack  input  1  framebuffer accepted write.
REQ-014 SHALL have ports busy  output  1  FSM not IDLE, and pkt_drop  output  1  one-cycle pulse, packet discarded.

Function
REQ-015 SHALL implement FSM states IDLE, MOVE, WRITE, with IDLE as reset state.
REQ-016 SHALL, in IDLE on pkt_valid, latch buttons and deltas and go to MOVE the next cycle.
REQ-017 SHALL, in MOVE, set x = clamp(x + sext(delta_x), 0, H_RES-1) and y = clamp(y - sext(delta_y), 0, V_RES-1), using signed arithmetic at least 2 bits wider than the position.
REQ-018 SHALL, in MOVE, advance the 3-bit palette index (7 wraps to 0) when latched btn_middle=1 and the previous packet's btn_middle=0.
REQ-019 SHALL, in MOVE, go to WRITE if latched btn_left=1, else to IDLE; cursor_x/cursor_y update on exit from MOVE.
REQ-020 SHALL, in WRITE, hold wr_req=1 with stable wr_addr/wr_data (new position, palette colour) until the cycle wr_ack=1, then deassert wr_req and return to IDLE the next cycle.
REQ-021 SHALL ignore wr_ack outside WRITE.
REQ-022 SHALL, on pkt_valid while not IDLE, discard the packet, leave state unchanged and pulse pkt_drop for one cycle.
REQ-023 SHALL give pkt-to-wr_req latency of exactly 2 cycles (pkt_valid at cycle N, wr_req high at N+2).
REQ-024 SHALL treat a packet with zero deltas and btn_left=1 as a write at the unchanged position.

Reset
REQ-025 SHALL, on reset, set cursor_x=H_RES/2, cursor_y=V_RES/2, palette index 0, previous-middle 0, wr_req=0, wr_addr=0, wr_data=0, busy=0, pkt_drop=0.
REQ-026 SHALL, on reset asserted mid-WRITE, drop wr_req on the next edge and abandon the write.

Configuration
REQ-027 SHALL, with PAINT_ERASE_EN defined, treat latched btn_right=1 with btn_left=0 as a write of colour 0 at the new position (btn_left wins if both are set).
REQ-028 SHALL, without PAINT_ERASE_EN, ignore btn_right entirely.

Structure
REQ-029 SHALL place FSM state encoding, the 8-entry palette colour constants and the reset-position defaults in shared package paint_pkg.
REQ-030 SHALL place the saturating signed add/clamp in sub-module sat_add, instantiated once per axis.

Verification
REQ-031 SHALL verify: reset, then packet dx=+5, dy=+3, left=1 -> cursor (37,29), wr_req at N+2, wr_addr=29*64+37, wr_data=palette[0].
REQ-032 SHALL verify: cursor at (60,2), packet dx=+100, dy=+50 -> cursor (63,0), no wr_req.
REQ-033 SHALL verify: cursor at (1,62), packet dx=-128, dy=-128 -> cursor (0,63).
REQ-034 SHALL verify: wr_ack withheld 10 cycles with a second pkt_valid during WRITE -> wr_req/addr/data stable, pkt_drop pulsed once, cursor unchanged by the second packet.
REQ-035 SHALL verify: 9 packets alternating middle=1 and middle=0 (5 rising edges) -> palette index 5, and 8 further rising edges wrap it back to 5.
REQ-036 SHALL verify: with PAINT_ERASE_EN, packet right=1, left=0 -> write with wr_data=0; without the macro -> no wr_req.

Source files
------------

// File: rtl/paint_pkg.sv
// Shared FSM encoding, palette constants and reset-position helper
// for the cursor paint controller.
package paint_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam int PAL_BITS = 24;

    localparam logic [PAL_BITS-1:0] PALETTE [8] = '{
        24'hFFFFFF,
        24'hFF0000,
        24'h00FF00,
        24'h0000FF,
        24'hFFFF00,
        24'h00FFFF,
        24'hFF00FF,
        24'h808080
    };

    function automatic int reset_pos(input int res);
        return res / 2;
    endfunction

endpackage

// File: rtl/cursor_paint_ctrl_if.sv
// Mouse-packet and framebuffer-write bundle for cursor_paint_ctrl.
// master = controller side, slave = mouse/framebuffer side.
interface cursor_paint_ctrl_if #(
    parameter int AW = 12,
    parameter int CW = 24
);
    logic          pkt_valid;
    logic          btn_left;
    logic          btn_right;
    logic          btn_middle;
    logic [7:0]    delta_x;
    logic [7:0]    delta_y;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          wr_ack;

    modport master (
        input  pkt_valid, btn_left, btn_right,
        input  btn_middle, delta_x, delta_y,
        input  wr_ack,
        output wr_req, wr_addr, wr_data
    );

    modport slave (
        output pkt_valid, btn_left, btn_right,
        output btn_middle, delta_x, delta_y,
        output wr_ack,
        input  wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/sat_add.sv
// Adds (or subtracts) a signed 8-bit delta to an unsigned position
// and clamps the result into 0..MAX.
module sat_add #(
    parameter int W   = 6,
    parameter int MAX = 63
) (
    input  logic [W-1:0] pos,
    input  logic [7:0]   delta,
    input  logic         sub,
    output logic [W-1:0] res
);
    localparam int SW = ((W > 8) ? W : 8) + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

    logic signed [SW-1:0] p_s;
    logic signed [SW-1:0] d_s;
    logic signed [SW-1:0] sum;

    always_comb begin
        p_s = $signed({{(SW-W){1'b0}}, pos});
        d_s = $signed({{(SW-8){delta[7]}}, delta});
        sum = sub ? (p_s - d_s) : (p_s + d_s);
        if (sum[SW-1]) begin
            res = '0;
        end else if (sum > MAX_S) begin
            res = W'(MAX);
        end else begin
            res = sum[W-1:0];
        end
    end
endmodule

// File: rtl/cursor_paint_ctrl.sv
// Mouse-driven cursor with framebuffer paint writes.
// Build option PAINT_ERASE_EN: right button alone paints colour 0.
module cursor_paint_ctrl
    import paint_pkg::*;
#(
    parameter int H_RES      = 64,
    parameter int V_RES      = 64,
    parameter int COLOR_BITS = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pkt_valid,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic                           btn_middle,
    input  logic [7:0]                     delta_x,
    input  logic [7:0]                     delta_y,
    output logic [$clog2(H_RES)-1:0]       cursor_x,
    output logic [$clog2(V_RES)-1:0]       cursor_y,
    output logic                           wr_req,
    output logic [$clog2(H_RES*V_RES)-1:0] wr_addr,
    output logic [COLOR_BITS-1:0]          wr_data,
    input  logic                           wr_ack,
    output logic                           busy,
    output logic                           pkt_drop
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam int AW = $clog2(H_RES*V_RES);

    state_e          state_q, state_d;
    logic            btn_l_q, btn_l_d;
    logic            btn_r_q, btn_r_d;
    logic            btn_m_q, btn_m_d;
    logic [7:0]      dx_q, dx_d;
    logic [7:0]      dy_q, dy_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [2:0]      pal_q, pal_d;
    logic            prev_m_q, prev_m_d;
    logic            wr_req_q, wr_req_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [COLOR_BITS-1:0] wr_data_q, wr_data_d;
    logic            drop_q, drop_d;

    logic [XW-1:0]   new_x;
    logic [YW-1:0]   new_y;
    logic [2:0]      pal_next;
    logic [AW-1:0]   pix_addr;
    logic            erase;

    sat_add #(.W(XW), .MAX(H_RES-1)) u_sat_x (
        .pos   (x_q),
        .delta (dx_q),
        .sub   (1'b0),
        .res   (new_x)
    );

    // Mouse Y grows upward, screen Y grows downward.
    sat_add #(.W(YW), .MAX(V_RES-1)) u_sat_y (
        .pos   (y_q),
        .delta (dy_q),
        .sub   (1'b1),
        .res   (new_y)
    );

`ifdef PAINT_ERASE_EN
    assign erase = btn_r_q && !btn_l_q;
`else
    logic unused_btn_r;
    assign unused_btn_r = btn_r_q;
    assign erase = 1'b0;
`endif

    assign pal_next = (btn_m_q && !prev_m_q) ? pal_q + 3'd1 : pal_q;
    assign pix_addr = AW'(new_y) * AW'(H_RES) + AW'(new_x);

    always_comb begin
        state_d   = state_q;
        btn_l_d   = btn_l_q;
        btn_r_d   = btn_r_q;
        btn_m_d   = btn_m_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        x_d       = x_q;
        y_d       = y_q;
        pal_d     = pal_q;
        prev_m_d  = prev_m_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        drop_d    = pkt_valid && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    btn_l_d = btn_left;
                    btn_r_d = btn_right;
                    btn_m_d = btn_middle;
                    dx_d    = delta_x;
                    dy_d    = delta_y;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                x_d      = new_x;
                y_d      = new_y;
                pal_d    = pal_next;
                prev_m_d = btn_m_q;
                if (btn_l_q || erase) begin
                    state_d   = WRITE;
                    wr_req_d  = 1'b1;
                    wr_addr_d = pix_addr;
                    wr_data_d = erase ? '0 :
                        COLOR_BITS'(PALETTE[pal_next]);
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            btn_l_q   <= 1'b0;
            btn_r_q   <= 1'b0;
            btn_m_q   <= 1'b0;
            dx_q      <= '0;
            dy_q      <= '0;
            x_q       <= XW'(reset_pos(H_RES));
            y_q       <= YW'(reset_pos(V_RES));
            pal_q     <= '0;
            prev_m_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_l_q   <= btn_l_d;
            btn_r_q   <= btn_r_d;
            btn_m_q   <= btn_m_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pal_q     <= pal_d;
            prev_m_q  <= prev_m_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            drop_q    <= drop_d;
        end
    end

    assign cursor_x = x_q;
    assign cursor_y = y_q;
    assign wr_req   = wr_req_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != IDLE);
    assign pkt_drop = drop_q;
endmodule

// File: tb/tb_cursor_paint_ctrl.sv
// Randomized self-checking bench for cursor_paint_ctrl (64x64, 24-bit).
// Expectations come from an arithmetic cursor/palette model.
module tb_cursor_paint_ctrl;

`ifdef PAINT_ERASE_EN
    localparam bit ERASE = 1'b1;
`else
    localparam bit ERASE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] cursor_x;
    logic [5:0] cursor_y;
    logic       busy;
    logic       pkt_drop;

    int n_tests = 0;
    int n_fail  = 0;

    int mx, my, mpal;
    bit mprev;

    logic [23:0] pal_tab [8] = '{
        24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h808080
    };

    cursor_paint_ctrl_if #(.AW(12), .CW(24)) bus ();

    cursor_paint_ctrl #(
        .H_RES(64), .V_RES(64), .COLOR_BITS(24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pkt_valid  (bus.pkt_valid),
        .btn_left   (bus.btn_left),
        .btn_right  (bus.btn_right),
        .btn_middle (bus.btn_middle),
        .delta_x    (bus.delta_x),
        .delta_y    (bus.delta_y),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .wr_req     (bus.wr_req),
        .wr_addr    (bus.wr_addr),
        .wr_data    (bus.wr_data),
        .wr_ack     (bus.wr_ack),
        .busy       (busy),
        .pkt_drop   (pkt_drop)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_pkt(input bit l, r, m,
                             input logic [7:0] dx, dy,
                             output bit wr,
                             output logic [23:0] col);
        mx = clampi(mx + int'($signed(dx)), 63);
        my = clampi(my - int'($signed(dy)), 63);
        if (m && !mprev) mpal = (mpal + 1) % 8;
        mprev = m;
        wr  = l || (ERASE && r);
        col = l ? pal_tab[mpal] : 24'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.wr_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mx = 32; my = 32; mpal = 0; mprev = 1'b0;
    endtask

    task automatic do_pkt(input bit l, r, m,
                          input logic [7:0] dx, dy,
                          input int ack_dly);
        bit wr;
        logic [23:0] col;
        int addr;
        model_pkt(l, r, m, dx, dy, wr, col);
        addr = my * 64 + mx;
        bus.btn_left = l;
        bus.btn_right = r;
        bus.btn_middle = m;
        bus.delta_x = dx;
        bus.delta_y = dy;
        bus.pkt_valid = 1'b1;
        @(negedge clk);
        bus.pkt_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || bus.wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL move_cycle busy=%b wr_req=%b want 1/0",
                     busy, bus.wr_req);
        end
        @(negedge clk);
        n_tests++;
        if (bus.wr_req !== wr) begin
            n_fail++;
            $display("FAIL wr_req_lat got %b want %b",
                     bus.wr_req, wr);
        end
        if (wr) begin
            n_tests++;
            if (bus.wr_addr !== 12'(addr) || bus.wr_data !== col) begin
                n_fail++;
                $display("FAIL wr_bus got %0d/%h want %0d/%h",
                         bus.wr_addr, bus.wr_data, addr, col);
            end
            repeat (ack_dly) begin
                @(negedge clk);
                n_tests++;
                if (bus.wr_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wr_hold got %b want 1", bus.wr_req);
                end
            end
            bus.wr_ack = 1'b1;
            @(negedge clk);
            bus.wr_ack = 1'b0;
            n_tests++;
            if (bus.wr_req !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_release got %b want 0", bus.wr_req);
            end
        end
        n_tests++;
        if (busy !== 1'b0 || cursor_x !== 6'(mx) ||
            cursor_y !== 6'(my)) begin
            n_fail++;
            $display("FAIL cursor got %0d,%0d busy=%b want %0d,%0d 0",
                     cursor_x, cursor_y, busy, mx, my);
        end
    endtask

    task automatic test_reset();
        do_reset();
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        n_tests++;
        if (cursor_x !== 6'd32 || cursor_y !== 6'd32 ||
            bus.wr_req !== 1'b0 || bus.wr_addr !== 12'd0 ||
            bus.wr_data !== 24'd0 || busy !== 1'b0 ||
            pkt_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset got %0d,%0d %b %0d %h %b %b",
                     cursor_x, cursor_y, bus.wr_req, bus.wr_addr,
                     bus.wr_data, busy, pkt_drop);
        end
    endtask

    task automatic test_basic_write();
        do_reset();
        do_pkt(1'b1, 1'b0, 1'b0, 8'd5, 8'd3, 2);
        n_tests++;
        if (cursor_x !== 6'd37 || cursor_y !== 6'd29 ||
            bus.wr_addr !== 12'd1893 ||
            bus.wr_data !== 24'hFFFFFF) begin
            n_fail++;
            $display("FAIL basic got %0d,%0d %0d %h want 37,29 1893",
                     cursor_x, cursor_y, bus.wr_addr, bus.wr_data);
        end
        do_pkt(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    endtask

    task automatic test_clamp_high();
        do_reset();
        do_pkt(1'b0, 1'b0, 1'b0, 8'd28, 8'd30, 0);
        do_pkt(1'b0, 1'b0, 1'b0, 8'd100, 8'd50, 0);
        n_tests++;
        if (cursor_x !== 6'd63 || cursor_y !== 6'd0) begin
            n_fail++;
            $display("FAIL clamp_high got %0d,%0d want 63,0",
                     cursor_x, cursor_y);
        end
    endtask

    task automatic test_clamp_low();
        do_reset();
        do_pkt(1'b0, 1'b0, 1'b0, 8'hE1, 8'hE2, 0);
        do_pkt(1'b0, 1'b0, 1'b0, 8'h80, 8'h80, 0);
        n_tests++;
        if (cursor_x !== 6'd0 || cursor_y !== 6'd63) begin
            n_fail++;
            $display("FAIL clamp_low got %0d,%0d want 0,63",
                     cursor_x, cursor_y);
        end
    endtask

    task automatic test_ack_stall();
        bit wr;
        logic [23:0] col;
        int addr;
        int drops;
        do_reset();
        model_pkt(1'b1, 1'b0, 1'b0, 8'd3, 8'hFE, wr, col);
        addr = my * 64 + mx;
        drops = 0;
        bus.btn_left = 1'b1;
        bus.btn_right = 1'b0;
        bus.btn_middle = 1'b0;
        bus.delta_x = 8'd3;
        bus.delta_y = 8'hFE;
        bus.pkt_valid = 1'b1;
        @(negedge clk);
        bus.pkt_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (bus.wr_req !== 1'b1 || bus.wr_addr !== 12'(addr) ||
                bus.wr_data !== col) begin
                n_fail++;
                $display("FAIL stall_hold %0d got %b %0d %h want 1 %0d %h",
                         i, bus.wr_req, bus.wr_addr, bus.wr_data,
                         addr, col);
            end
            if (pkt_drop === 1'b1) drops++;
            bus.pkt_valid = (i == 2);
            bus.delta_x = 8'd7;
            bus.delta_y = 8'd7;
            @(negedge clk);
        end
        bus.pkt_valid = 1'b0;
        if (pkt_drop === 1'b1) drops++;
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        if (pkt_drop === 1'b1) drops++;
        n_tests++;
        if (drops != 1) begin
            n_fail++;
            $display("FAIL drop_count got %0d want 1", drops);
        end
        n_tests++;
        if (bus.wr_req !== 1'b0 || busy !== 1'b0 ||
            cursor_x !== 6'd35 || cursor_y !== 6'd34) begin
            n_fail++;
            $display("FAIL stall_end got %b %b %0d,%0d want 0 0 35,34",
                     bus.wr_req, busy, cursor_x, cursor_y);
        end
    endtask

    task automatic test_palette();
        do_reset();
        for (int i = 0; i < 9; i++)
            do_pkt(1'b1, 1'b0, (i % 2) == 0, 8'd0, 8'd0, 0);
        n_tests++;
        if (bus.wr_data !== 24'h00FFFF) begin
            n_fail++;
            $display("FAIL palette5 got %h want 00ffff", bus.wr_data);
        end
        for (int i = 0; i < 16; i++)
            do_pkt(1'b1, 1'b0, (i % 2) == 1, 8'd0, 8'd0, 0);
        n_tests++;
        if (bus.wr_data !== 24'h00FFFF) begin
            n_fail++;
            $display("FAIL palette_wrap got %h want 00ffff",
                     bus.wr_data);
        end
    endtask

    task automatic test_erase();
        do_reset();
        do_pkt(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 0);
        do_pkt(1'b0, 1'b1, 1'b0, 8'd4, 8'd4, 1);
        do_pkt(1'b1, 1'b1, 1'b0, 8'd2, 8'd2, 0);
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        bus.btn_left = 1'b1;
        bus.btn_right = 1'b0;
        bus.btn_middle = 1'b0;
        bus.delta_x = 8'd9;
        bus.delta_y = 8'd9;
        bus.pkt_valid = 1'b1;
        @(negedge clk);
        bus.pkt_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (bus.wr_req !== 1'b0 || busy !== 1'b0 ||
            cursor_x !== 6'd32 || cursor_y !== 6'd32) begin
            n_fail++;
            $display("FAIL reset_mid got %b %b %0d,%0d want 0 0 32,32",
                     bus.wr_req, busy, cursor_x, cursor_y);
        end
        mx = 32; my = 32; mpal = 0; mprev = 1'b0;
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        do_pkt(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            do_pkt(1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.btn_left = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_middle = 1'b0;
        bus.delta_x = 8'd0;
        bus.delta_y = 8'd0;
        bus.wr_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_write();
        test_clamp_high();
        test_clamp_low();
        test_ack_stall();
        test_palette();
        test_erase();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
